// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a ROM table of register writes into the I2C controller command port (define I2C_CFG_READBACK_EN to read back and verify every write)
module i2c_config_sequencer #(
    parameter logic [7:0] SLAVE_ADDR     = 8'h72,
    parameter int         ROM_AW         = 6,
    parameter int         DELAY_UNIT     = 1000,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              i2c_ctrl_valid,
    input  logic              i2c_ctrl_ready,
    output logic [15:0]       i2c_slave_addr,
    output logic [15:0]       i2c_reg_addr,
    output logic [15:0]       i2c_wdata,
    input  logic [15:0]       i2c_rdata,
    input  logic              i2c_rdata_valid
);
    localparam int DMAX = 255 * DELAY_UNIT;
    localparam int CW   = $clog2(((DMAX > TIMEOUT_CYCLES) ? DMAX : TIMEOUT_CYCLES) + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, DELAY, ISSUE, ACCEPT, COMPLETE, NEXT, DONE, ERR
`ifdef I2C_CFG_READBACK_EN
        , VERIFY, CHECK
`endif
    } state_t;

    state_t        state, nxt, after_cmd;
    logic [CW-1:0] cnt;
    logic          rw;
    logic          tmo_hit;
    logic          unused;

    assign tmo_hit        = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign i2c_slave_addr = {8'h00, SLAVE_ADDR[7:1], rw};
    // valid is decoded from state and masked by reset so an abort drops it at once
    assign i2c_ctrl_valid = (state == ISSUE || state == ACCEPT) && !reset;

`ifdef I2C_CFG_READBACK_EN
    logic rd_ok;
    assign rd_ok     = i2c_rdata_valid && i2c_rdata[7:0] == i2c_wdata[7:0];
    assign after_cmd = rw ? CHECK : VERIFY;
    assign unused    = ^i2c_rdata[15:8];
`else
    assign after_cmd = NEXT;
    assign unused    = ^{i2c_rdata, i2c_rdata_valid};
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next-state: table walk, two-phase ready handshake and timeout
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:     nxt = start ? FETCH : IDLE;
            FETCH:    nxt = DECODE;
            DECODE:   nxt = rom_data[15:8] == 8'hFF ? DONE :
                            rom_data[15:8] != 8'hFE ? ISSUE :
                            rom_data[7:0] == 8'h00 ? NEXT : DELAY;
            ISSUE:    nxt = ACCEPT;
            ACCEPT:   nxt = !i2c_ctrl_ready ? COMPLETE : tmo_hit ? ERR : ACCEPT;
            COMPLETE: nxt = i2c_ctrl_ready ? after_cmd : tmo_hit ? ERR : COMPLETE;
            DELAY:    nxt = cnt <= CW'(1) ? NEXT : DELAY;
            NEXT:     nxt = &rom_addr ? DONE : FETCH;
`ifdef I2C_CFG_READBACK_EN
            VERIFY:   nxt = ISSUE;
            CHECK:    nxt = rd_ok ? NEXT : ERR;
`endif
            default:  nxt = IDLE;
        endcase
    end

    // datapath: ROM address, command registers, shared delay/timeout counter, status
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
            i2c_reg_addr <= '0;
            i2c_wdata    <= '0;
            rw           <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rom_addr  <= '0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    err_index <= '0;
                end
                DECODE: begin
                    cnt <= CW'(rom_data[7:0] * DELAY_UNIT);
                    if (nxt == ISSUE) begin
                        i2c_reg_addr <= {8'h01, rom_data[15:8]};
                        i2c_wdata    <= {8'h00, rom_data[7:0]};
                        rw           <= 1'b0;
                    end
                end
                ISSUE:    cnt <= '0;
                ACCEPT:   cnt <= nxt == COMPLETE ? '0 : cnt + 1'b1;
                COMPLETE: cnt <= cnt + 1'b1;
                DELAY:    cnt <= cnt - 1'b1;
                NEXT:     if (nxt == FETCH) rom_addr <= rom_addr + 1'b1;
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                ERR: begin
                    error     <= 1'b1;
                    err_index <= rom_addr;
                    busy      <= 1'b0;
                end
`ifdef I2C_CFG_READBACK_EN
                VERIFY:   rw <= 1'b1;
                CHECK:    rw <= 1'b0;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: randomized self-checking bench with ROM, controller and table-walk reference model
module tb_i2c_config_sequencer;
    localparam int AW = 4;
    localparam int N  = 1 << AW;

    typedef struct { logic [15:0] sa; logic [15:0] ra; logic [15:0] wd; } cmd_t;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] err_index, rom_addr;
    logic [15:0]   rom_data = '0;
    logic          i2c_ctrl_valid, i2c_ctrl_ready = 1'b1;
    logic [15:0]   i2c_slave_addr, i2c_reg_addr, i2c_wdata;
    logic [15:0]   i2c_rdata = '0;
    logic          i2c_rdata_valid = 1'b0;

    logic [15:0] rom [N];
    logic [7:0]  dev [256];
    cmd_t        got[$], exp[$];
    int          n_cmp = 0, n_bad = 0;
    bit          stuck = 1'b0;
    int          drop_dly = 2, busy_len = 50;
    logic [7:0]  rb_xor = 8'h00;

    i2c_config_sequencer #(
        .SLAVE_ADDR(8'h72), .ROM_AW(AW), .DELAY_UNIT(10), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_ctrl_valid(i2c_ctrl_valid), .i2c_ctrl_ready(i2c_ctrl_ready),
        .i2c_slave_addr(i2c_slave_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata), .i2c_rdata_valid(i2c_rdata_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // controller model: accepts on the falling edge, leaves idle after drop_dly, returns busy_len later
    initial begin
        forever begin
            @(negedge clk);
            if (i2c_ctrl_valid && i2c_ctrl_ready && !stuck) begin
                got.push_back('{i2c_slave_addr, i2c_reg_addr, i2c_wdata});
                if (!i2c_slave_addr[0]) dev[i2c_reg_addr[7:0]] = i2c_wdata[7:0];
                i2c_rdata_valid = 1'b0;
                repeat (drop_dly - 1) @(negedge clk);
                i2c_ctrl_ready = 1'b0;
                repeat (busy_len) @(negedge clk);
                i2c_ctrl_ready = 1'b1;
                if (got[$].sa[0]) begin
                    i2c_rdata       = {8'h00, dev[got[$].ra[7:0]] ^ rb_xor};
                    i2c_rdata_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic void fill_rom();
        foreach (rom[i]) rom[i] = 16'hFF00;
    endfunction

    // expected command stream: every ordinary entry up to end marker or table end is one write (plus readback)
    function automatic void build_exp();
        exp.delete();
        for (int i = 0; i < N; i++) begin
            if (rom[i][15:8] == 8'hFF) break;
            if (rom[i][15:8] != 8'hFE) begin
                exp.push_back('{16'h0072, {8'h01, rom[i][15:8]}, {8'h00, rom[i][7:0]}});
`ifdef I2C_CFG_READBACK_EN
                exp.push_back('{16'h0073, {8'h01, rom[i][15:8]}, {8'h00, rom[i][7:0]}});
`endif
            end
        end
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1 cyc++;
        end
    endtask

    task automatic run_seq(output int cyc, output bit to);
        pulse_start();
        wait_idle(cyc, to);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({i2c_ctrl_valid, busy, done, error} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {i2c_ctrl_valid, busy, done, error}); end
        n_cmp++; if (err_index !== '0 || rom_addr !== '0) begin n_bad++; $display("FAIL reset_addr: err_index %0d rom_addr %0d want 0 0", err_index, rom_addr); end
        n_cmp++; if (i2c_slave_addr !== 16'h0072) begin n_bad++; $display("FAIL reset_slave: got %h want 0072", i2c_slave_addr); end
        n_cmp++; if ({i2c_reg_addr, i2c_wdata} !== 32'h0) begin n_bad++; $display("FAIL reset_cmd: got %h want 0", {i2c_reg_addr, i2c_wdata}); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, nw;
        bit to;
        logic [31:0] w0;
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'h9803;
        drop_dly = 2; busy_len = 50;
        got.delete();
        build_exp();
        run_seq(cyc, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_finish: still busy after %0d cycles", cyc); end
        n_cmp++;
        if (got.size() != exp.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got.size(), exp.size()); end
        else foreach (exp[i]) begin
            n_cmp++;
            if (got[i].sa !== exp[i].sa || got[i].ra !== exp[i].ra || (!exp[i].sa[0] && got[i].wd !== exp[i].wd)) begin
                n_bad++; $display("FAIL basic_cmd%0d: got %h/%h/%h want %h/%h/%h", i, got[i].sa, got[i].ra, got[i].wd, exp[i].sa, exp[i].ra, exp[i].wd);
            end
        end
        nw = 0; w0 = '0;
        foreach (got[i]) if (!got[i].sa[0]) begin
            if (nw == 0) w0 = {got[i].ra, got[i].wd};
            nw++;
        end
        n_cmp++; if (nw != 2) begin n_bad++; $display("FAIL basic_writes: got %0d want 2", nw); end
        n_cmp++; if (w0 !== 32'h0141_0010) begin n_bad++; $display("FAIL basic_first: got %h want 01410010", w0); end
        n_cmp++; if ({done, busy, error} !== 3'b100) begin n_bad++; $display("FAIL basic_status: done/busy/error %b want 100", {done, busy, error}); end
    endtask

    task automatic test_delay();
        int c0, c1;
        bit to0, to1;
        fill_rom();
        rom[0] = 16'hFE00;
        got.delete();
        run_seq(c0, to0);
        rom[0] = 16'hFE03;
        run_seq(c1, to1);
        n_cmp++; if (to0 || to1) begin n_bad++; $display("FAIL delay_finish: timeouts %b%b want 00", to0, to1); end
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL delay_valid: got %0d commands want 0", got.size()); end
        n_cmp++; if (c1 - c0 < 27 || c1 - c0 > 33) begin n_bad++; $display("FAIL delay_len: got %0d extra cycles want 30+-3", c1 - c0); end
        n_cmp++; if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL delay_status: done/error %b want 10", {done, error}); end
    endtask

    task automatic test_timeout();
        int lat, cyc;
        bit to;
        stuck = 1'b1;
        fill_rom();
        rom[0] = 16'h1234;
        pulse_start();
        for (int i = 0; i < 50 && !i2c_ctrl_valid; i++) begin @(posedge clk); #1; end
        lat = 0;
        for (int i = 0; i < 500 && !error; i++) begin @(posedge clk); #1 lat++; end
        n_cmp++; if (lat < 95 || lat > 110) begin n_bad++; $display("FAIL tmo_latency: got %0d cycles want about 100", lat); end
        n_cmp++; if ({error, busy, done, i2c_ctrl_valid} !== 4'b1000) begin n_bad++; $display("FAIL tmo_status: error/busy/done/valid %b want 1000", {error, busy, done, i2c_ctrl_valid}); end
        n_cmp++; if (err_index !== '0) begin n_bad++; $display("FAIL tmo_index0: got %0d want 0", err_index); end
        rom[0] = 16'hFE00; rom[1] = 16'h1234;
        run_seq(cyc, to);
        n_cmp++; if (to || err_index !== AW'(1) || !error) begin n_bad++; $display("FAIL tmo_index1: err_index %0d error %b want 1 1", err_index, error); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'h9803;
        drop_dly = 2; busy_len = 50;
        build_exp();
        pulse_start();
        for (int i = 0; i < 50 && i2c_ctrl_ready; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n_cmp++; if ({i2c_ctrl_valid, busy, done} !== 3'b000) begin n_bad++; $display("FAIL rstmid_status: valid/busy/done %b want 000", {i2c_ctrl_valid, busy, done}); end
        n_cmp++; if (rom_addr !== '0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", rom_addr); end
        for (int i = 0; i < 200 && !i2c_ctrl_ready; i++) begin @(posedge clk); #1; end
        got.delete();
        run_seq(cyc, to);
        n_cmp++;
        if (to || got.size() != exp.size()) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d (timeout %b)", got.size(), exp.size(), to); end
        else foreach (exp[i]) begin
            n_cmp++;
            if (got[i].sa !== exp[i].sa || got[i].ra !== exp[i].ra || (!exp[i].sa[0] && got[i].wd !== exp[i].wd)) begin
                n_bad++; $display("FAIL rstmid_cmd%0d: got %h/%h/%h want %h/%h/%h", i, got[i].sa, got[i].ra, got[i].wd, exp[i].sa, exp[i].ra, exp[i].wd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        fill_rom();
        rom[0] = 16'h0C5A; rom[1] = 16'h33A5;
        busy_len = $urandom_range(5, 30);
        build_exp();
        got.delete();
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_start();
        wait_idle(cyc, to);
        n_cmp++; if (to || got.size() != exp.size()) begin n_bad++; $display("FAIL b2b_ignored: got %0d commands want %0d (timeout %b)", got.size(), exp.size(), to); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", done); end
        pulse_start();
        n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_restart: done/busy %b want 01", {done, busy}); end
        wait_idle(cyc, to);
        n_cmp++; if (to || got.size() != 2 * exp.size() || done !== 1'b1) begin n_bad++; $display("FAIL b2b_rerun: got %0d commands done %b want %0d 1", got.size(), done, 2 * exp.size()); end
    endtask

    task automatic test_random();
        int cyc, len;
        bit to;
        for (int it = 0; it < 6; it++) begin
            fill_rom();
            len = (it == 0) ? N : $urandom_range(1, N - 1);
            for (int i = 0; i < len; i++)
                rom[i] = ($urandom_range(0, 4) == 0) ? {8'hFE, 8'($urandom_range(0, 2))}
                                                     : {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            drop_dly = $urandom_range(1, 3);
            busy_len = $urandom_range(3, 60);
            build_exp();
            got.delete();
            run_seq(cyc, to);
            n_cmp++;
            if (to || got.size() != exp.size()) begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d (timeout %b)", it, got.size(), exp.size(), to); end
            else foreach (exp[i]) begin
                n_cmp++;
                if (got[i].sa !== exp[i].sa || got[i].ra !== exp[i].ra || (!exp[i].sa[0] && got[i].wd !== exp[i].wd)) begin
                    n_bad++; $display("FAIL rand%0d_cmd%0d: got %h/%h/%h want %h/%h/%h", it, i, got[i].sa, got[i].ra, got[i].wd, exp[i].sa, exp[i].ra, exp[i].wd);
                end
            end
            n_cmp++; if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL rand%0d_status: done/error %b want 10", it, {done, error}); end
        end
    endtask

`ifdef I2C_CFG_READBACK_EN
    task automatic test_readback();
        int cyc;
        bit to;
        fill_rom();
        rom[0] = 16'h2A55;
        drop_dly = 2; busy_len = 20;
        rb_xor = 8'h01;
        got.delete();
        run_seq(cyc, to);
        n_cmp++; if (to || got.size() != 2) begin n_bad++; $display("FAIL rb_count: got %0d want 2 (timeout %b)", got.size(), to); end
        else begin
            n_cmp++; if ({got[0].sa, got[0].ra, got[0].wd} !== 48'h0072_012A_0055) begin n_bad++; $display("FAIL rb_write: got %h/%h/%h want 0072/012a/0055", got[0].sa, got[0].ra, got[0].wd); end
            n_cmp++; if ({got[1].sa, got[1].ra} !== 32'h0073_012A) begin n_bad++; $display("FAIL rb_read: got %h/%h want 0073/012a", got[1].sa, got[1].ra); end
        end
        n_cmp++; if ({error, done, busy} !== 3'b100 || err_index !== '0) begin n_bad++; $display("FAIL rb_mismatch: error/done/busy %b idx %0d want 100 0", {error, done, busy}, err_index); end
        rb_xor = 8'h00;
        run_seq(cyc, to);
        n_cmp++; if (to || {done, error} !== 2'b10) begin n_bad++; $display("FAIL rb_match: done/error %b want 10", {done, error}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef I2C_CFG_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
